// File: rtl/ctc_pkg.sv
// ctc_pkg: shared types and constants for the Z80 CTC interrupt controller.
//   ch_state_e   : per-channel interrupt state (idle / pending / in service)
//   reti_state_e : RETI opcode snoop FSM states
//   OP_ED/OP_RETI2 : the two bytes of the RETI instruction (ED 4D)
//   NCH_MAX      : largest channel count the 2-bit vector field can encode
package ctc_pkg;
  localparam int         NCH_MAX  = 4;
  localparam logic [7:0] OP_ED    = 8'hED;
  localparam logic [7:0] OP_RETI2 = 8'h4D;

  typedef enum logic [1:0] {CH_IDLE, CH_PEND, CH_SERV} ch_state_e;
  typedef enum logic [1:0] {RS_IDLE, RS_SAW_ED, RS_RETI} reti_state_e;
endpackage

// File: rtl/ctc_reti_snoop.sv
// ctc_reti_snoop: watches opcode fetches on the Z80 bus for ED 4D (RETI).
// An opcode byte is sampled once per fetch, on the first cycle of
// M1 && RD && !IORQ. After the second RETI byte the FSM sits in RS_RETI
// for exactly one cycle, which is the reti_pulse_o output.
// Ports:
//   clk, reset_n     : clock, async active-low reset
//   m1_n_i, rd_n_i, iorq_n_i : Z80 bus strobes
//   din_i            : Z80 data bus (opcode byte in [7:0])
//   reti_pulse_o     : one-cycle pulse following a recognised RETI
module ctc_reti_snoop
  import ctc_pkg::*;
#(
  parameter int DWID = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m1_n_i,
  input  logic            rd_n_i,
  input  logic            iorq_n_i,
  input  logic [DWID-1:0] din_i,
  output logic            reti_pulse_o
);
  reti_state_e state_q, state_d;
  logic        fetch, fetch_q, sample;

  assign fetch  = !m1_n_i && !rd_n_i && iorq_n_i;
  assign sample = fetch && !fetch_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RS_IDLE;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RS_IDLE:
        if (sample && din_i[7:0] == OP_ED) state_d = RS_SAW_ED;
      RS_SAW_ED:
        if (sample) begin
          if (din_i[7:0] == OP_RETI2)   state_d = RS_RETI;
          else if (din_i[7:0] == OP_ED) state_d = RS_SAW_ED; // ED ED 4D still counts
          else                          state_d = RS_IDLE;
        end
      RS_RETI: state_d = RS_IDLE;
      default: state_d = RS_IDLE;
    endcase
  end

  assign reti_pulse_o = (state_q == RS_RETI);
endmodule

// File: rtl/ctc_int_ctrl.sv
// ctc_int_ctrl: interrupt controller for a 4-channel Z80 CTC.
// Zero-count rising edges (gated by int_en) raise per-channel pending bits.
// Pending channels request via int_n with fixed priority (ch0 highest);
// INTACK moves the winner to service and drives the mode-2 vector
// {vec_base, ch, 0}. A snooped RETI (with iei high) retires the
// lowest-index in-service channel. Any in-service channel blocks new
// requests and holds ieo low.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   m1_n, iorq_n, rd_n    : Z80 bus strobes
//   din                   : Z80 data bus (vector write, opcode snoop)
//   vec_wstb              : vector register write strobe (ch0 decode)
//   zc_to, int_en, chan_rst : per-channel zero-count, enable, soft reset
//   iei / ieo             : daisy-chain in / out
//   int_n                 : interrupt request (registered, active low)
//   dout, oe_n            : vector output and its enable during INTACK
//   overrun               : per-channel lost-event flag
//                           (only with CTC_INT_OVERRUN_EN defined)
module ctc_int_ctrl
  import ctc_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int DWID = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m1_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic [DWID-1:0] din,
  input  logic            vec_wstb,
  input  logic [NCH-1:0]  zc_to,
  input  logic [NCH-1:0]  int_en,
  input  logic [NCH-1:0]  chan_rst,
  input  logic            iei,
  output logic            ieo,
  output logic            int_n,
  output logic [DWID-1:0] dout,
  output logic            oe_n
`ifdef CTC_INT_OVERRUN_EN
  ,
  output logic [NCH-1:0]  overrun
`endif
);
  logic [NCH-1:0] zc_q, pend_q, pend_d, serv_q, serv_d;
  logic [NCH-1:0] ev, win_oh, grant, serv_lo, reti_clr;
  logic [4:0]     vec_base_q, vec_base_d;
  logic [1:0]     ch_q, ch_d, win_idx;
  logic           ack_q, oe_q, oe_d, int_n_q, int_n_d;
  logic           ack_term, ack_det, ack_go, blk, any_pend, reti_pulse, oe;

  ctc_reti_snoop #(.DWID(DWID)) u_snoop (
    .clk          (clk),
    .reset_n      (reset_n),
    .m1_n_i       (m1_n),
    .rd_n_i       (rd_n),
    .iorq_n_i     (iorq_n),
    .din_i        (din),
    .reti_pulse_o (reti_pulse)
  );

  assign ev       = zc_to & ~zc_q & int_en;
  assign any_pend = |pend_q;
  assign blk      = |serv_q;

  // lowest set bit = highest priority
  assign win_oh  = pend_q & (~pend_q + NCH'(1));
  assign serv_lo = serv_q & (~serv_q + NCH'(1));

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NCH; i++)
      if (win_oh[i]) win_idx = 2'(i);
  end

  // INTACK is taken on the first cycle of M1 && IORQ only
  assign ack_term = !m1_n && !iorq_n;
  assign ack_det  = ack_term && !ack_q;
  assign ack_go   = ack_det && iei && any_pend;
  assign grant    = ack_go ? win_oh : '0;
  assign reti_clr = (reti_pulse && iei) ? serv_lo : '0;

  // chan_rst overrides everything; an event re-arms pend even as the
  // same channel is granted or retired this cycle.
  assign pend_d = ((pend_q & ~grant) | ev) & ~chan_rst;
  assign serv_d = ((serv_q & ~reti_clr) | grant) & ~chan_rst;

  always_comb begin
    oe_d = oe_q;
    if (ack_det)        oe_d = ack_go;
    else if (!ack_term) oe_d = 1'b0;
  end

  assign ch_d       = ack_go ? win_idx : ch_q;
  assign vec_base_d = (vec_wstb && !din[0]) ? din[7:3] : vec_base_q;
  assign int_n_d    = !(iei && !blk && any_pend);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zc_q       <= '0;
      pend_q     <= '0;
      serv_q     <= '0;
      vec_base_q <= '0;
      ch_q       <= '0;
      ack_q      <= 1'b0;
      oe_q       <= 1'b0;
      int_n_q    <= 1'b1;
    end else begin
      zc_q       <= zc_to;
      pend_q     <= pend_d;
      serv_q     <= serv_d;
      vec_base_q <= vec_base_d;
      ch_q       <= ch_d;
      ack_q      <= ack_term;
      oe_q       <= oe_d;
      int_n_q    <= int_n_d;
    end
  end

`ifdef CTC_INT_OVERRUN_EN
  logic [NCH-1:0] ovr_q, ovr_d;
  // an event is lost only if pend stays set (not consumed by a grant)
  assign ovr_d = (ovr_q | (ev & pend_q & ~grant)) & ~chan_rst;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovr_q <= '0;
    else          ovr_q <= ovr_d;
  end
  assign overrun = ovr_q;
`endif

  // gate with the live bus term so the bus is released as soon as
  // IORQ/M1 rise, and with reset_n so ieo is low while in reset
  assign oe    = oe_q && ack_term;
  assign oe_n  = !oe;
  assign dout  = oe ? DWID'({vec_base_q, ch_q, 1'b0}) : '0;
  assign int_n = int_n_q;
  assign ieo   = reset_n && iei && !blk && !any_pend;
endmodule

// File: doc/ctc_int_ctrl.md
Name: ctc_int_ctrl

Overview:
- Interrupt controller for a 4-channel Z80 CTC. Sits between the per-channel counter/timer cores and the Z80 bus.
- Turns channel zero-count events into pending interrupts and arbitrates them with fixed priority (ch0 highest).
- Drives int_n and the IEI/IEO daisy chain, supplies the mode-2 vector during interrupt acknowledge, and snoops RETI (ED 4D) to retire the in-service channel.

Parameters:
NCH, 4, number of channels (vector encoding supports up to 4)
DWID, 8, data bus width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m1_n  in  1  Z80 M1
iorq_n  in  1  Z80 IORQ
rd_n  in  1  Z80 RD
din  in  DWID  Z80 data bus (vector writes, opcode snoop)
vec_wstb  in  1  one-cycle strobe: vector-register write decoded for channel 0
zc_to  in  NCH  per-channel zero-count level from the channel cores
int_en  in  NCH  per-channel interrupt enable (CCW bit 7)
chan_rst  in  NCH  per-channel software-reset pulse (CCW bit 1)
iei  in  1  daisy-chain enable in
ieo  out  1  daisy-chain enable out
int_n  out  1  interrupt request, active low
dout  out  DWID  vector during INTACK, 0 otherwise
oe_n  out  1  data output enable, active low

Behaviour:
- Reset: int_n=1, ieo=0, oe_n=1, dout=0. Vector base=0. All pending/in-service bits cleared. RETI FSM=IDLE. zc edge registers=0.
- Vector write: vec_wstb && !din[0] -> vec_base <= din[7:3]. A strobe with din[0]=1 is ignored.
- Event capture: rising edge of zc_to[i] (registered compare) && int_en[i] -> pend[i]=1 on the next clk. An edge while int_en[i]=0 is dropped.
- Per-channel state: IDLE -> PEND (event) -> SERV (acknowledged) -> IDLE (RETI).
  - chan_rst[i] forces IDLE from any state; reset wins over a same-cycle event.
  - An event arriving while a channel is in PEND or SERV only sets the pending bit (one level of queuing). A further event while pend=1 is lost.
- Request blocking: blk = any SERV bit set.
- int_n (registered): 0 iff iei && !blk && any pend.
- ieo (combinational): iei && !blk && !(any pend).
- INTACK: detected on the first cycle that m1_n=0 && iorq_n=0 (rising-edge detect of that term).
  - Winner = lowest-index pending channel, sampled in that same cycle; it moves PEND -> SERV.
  - dout = {vec_base, ch[1:0], 1'b0} and oe_n=0 from the cycle after detection until iorq_n or m1_n deasserts. Latency 1 clk.
  - If iei=0 or nothing is pending at detection: no state change, oe_n stays 1.
  - A same-cycle zc event is not eligible for that acknowledge.
- RETI snoop FSM, sampled on the rising edge of (m1_n=0 && rd_n=0 && iorq_n=1):
  - IDLE: din==ED -> SAW_ED.
  - SAW_ED: din==4D -> RETI; din==ED -> stay in SAW_ED; any other value -> IDLE.
  - RETI lasts one cycle: if iei=1, clear the lowest-index SERV channel, then return to IDLE. If iei=0, the RETI belongs to a higher-priority device and is ignored.
- Simultaneous RETI and new event on the same channel: the service bit clears, the pend bit sets, and the channel re-requests.

Optional Feature:
- Macro CTC_INT_OVERRUN_EN.
- Defined: adds output overrun[NCH-1:0], reset 0. overrun[i] sets when an event arrives while pend[i]=1, and clears on chan_rst[i].
- Undefined: port absent; the lost event is silent.

Decomposition:
- Shared package ctc_pkg holds:
  - channel state enum (IDLE/PEND/SERV)
  - RETI FSM enum
  - opcode constants OP_ED=8'hED, OP_RETI2=8'h4D
  - NCH_MAX=4
- One sub-module: ctc_reti_snoop (FSM plus M1-edge detect, outputs a 1-cycle reti_pulse).
- Priority encoder and per-channel state stay inline.

Test Plan:
- Vector and acknowledge: write vector 8'hA0 via vec_wstb; zc_to[2] pulse with int_en=4'hF -> int_n=0 within 2 clk; INTACK -> dout=8'hA4, oe_n=0 one clk after detection; ieo=0.
- Priority: zc_to[3] and zc_to[1] on the same clk -> first INTACK gives vector for ch1 (8'hA2). After ED 4D, int_n=0 again and the second INTACK gives 8'hA6.
- Blocking: ch0 in service, new ch2 event -> int_n stays 1 and ieo=0 until RETI, then int_n=0.
- RETI snoop: opcode fetch sequence ED,00,4D -> no clear. Sequence ED,ED,4D -> the SERV channel clears. With iei=0, ED 4D -> no clear.
- Software reset: pending ch1 plus chan_rst[1] on the same cycle as a new zc_to[1] edge -> state IDLE, int_n=1. An async reset_n mid-INTACK -> oe_n=1, dout=0 immediately.
- Overrun (CTC_INT_OVERRUN_EN): two ch3 events with no acknowledge -> overrun=4'b1000; chan_rst[3] -> 0.
